i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_BITS, default 16, sample width captured per channel slot.
REQ-002 CLK  input  1  system clock (100 MHz domain); all state changes on rising edge.
REQ-003 RSTb  input  1  asynchronous, active-low reset.
REQ-004 sclk  input  1  I2S bit clock, asynchronous to CLK; frequency <= CLK/4.
REQ-005 lr_clk  input  1  I2S word select, asynchronous to CLK; 0 = left slot, 1 = right slot.
REQ-006 sdat  input  1  I2S serial data, MSB first, two's complement.
REQ-007 left_out  output  DATA_BITS  last complete left sample.
REQ-008 right_out  output  DATA_BITS  last complete right sample.
REQ-009 out_tick  output  1  one-CLK pulse; new left/right pair valid.
REQ-010 slot_err  output  1  one-CLK pulse; the just-completed slot was shorter than DATA_BITS bits.
REQ-011 locked  output  1  high once word-select alignment has been acquired.

Function
REQ-012 sclk, lr_clk and sdat SHALL each pass through an identical 2-flop synchronizer; a rising edge SHALL be detected by a third register on synchronized sclk (sync=1, delayed=0).
REQ-013 On each detected sclk rising edge, the synchronized sdat and lr_clk SHALL be sampled together.
REQ-014 A WS change is a sampled lr_clk that differs from the value sampled at the previous sclk rising edge.
REQ-015 The sdat bit sampled on a WS-change edge SHALL belong to the old slot (its LSB); the new slot's MSB is the bit at the next sclk rising edge.
REQ-016 Within a slot, the first DATA_BITS bits SHALL shift in MSB-first; later bits SHALL be ignored; the bit counter SHALL saturate and never wrap.
REQ-017 If a slot ends with n < DATA_BITS bits, the word SHALL be the n bits left-justified with zero-filled LSBs, and slot_err SHALL pulse for one cycle.
REQ-018 FSM states: SYNC, LEFT, RIGHT.
REQ-019 SYNC: no words are output; at the first WS change, go to LEFT if sampled lr_clk=0, otherwise RIGHT; locked SHALL rise in the same cycle.
REQ-020 A slot entered directly from SYNC is complete; the partial slot before the first WS change is discarded and does not trigger slot_err.
REQ-021 LEFT to RIGHT on a WS change: hold the finished word in an internal left staging register; left_out is unchanged.
REQ-022 RIGHT to LEFT on a WS change: load left_out from staging and right_out from the finished word in the same cycle, and pulse out_tick.
REQ-023 out_tick SHALL not fire for a RIGHT slot unless it was preceded by a LEFT slot completed since lock.
REQ-024 Latency: out_tick, slot_err and output updates SHALL occur exactly 4 CLK rising edges after the first CLK edge that samples sclk=1 at the pin (2 sync + 1 edge detect + 1 output register).
REQ-025 left_out and right_out SHALL hold their values between out_tick pulses.
REQ-026 Slot lengths may change frame to frame; each slot is handled independently under REQ-016/017.

Reset
REQ-027 With RSTb low: left_out=0, right_out=0, staging=0, out_tick=0, slot_err=0, locked=0, FSM=SYNC, bit counter=0, synchronizers=0, taking effect immediately without waiting for CLK.
REQ-028 Asserting reset mid-slot SHALL discard all partial data; after release, behaviour SHALL be as from power-up (REQ-019/020).

Verification
REQ-029 16-bit slots, left=0x1234, right=0xABCD, sclk=CLK/8 -> one out_tick; left_out=0x1234, right_out=0xABCD; slot_err never pulses.
REQ-030 32-bit slots, left=0x8001_5555, right=0x7FFE_AAAA -> left_out=0x8001, right_out=0x7FFE; no slot_err.
REQ-031 12-bit slots, left=0xABC, right=0x123 -> left_out=0xABC0, right_out=0x1230; slot_err pulses twice per frame.
REQ-032 Release reset mid-right-slot -> locked rises at first WS change; no out_tick until one full left plus one full right slot; first pair is correct.
REQ-033 Assert RSTb low mid-frame after valid data -> all outputs 0 asynchronously; locked=0; resynchronizes as in REQ-032.
REQ-034 Ten back-to-back 16-bit frames with incrementing samples -> exactly ten out_tick pulses, spaced 32 sclk periods apart, each matching the sent pair with 4-cycle latency.

Source files
------------

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver that synchronizes the bit clock, aligns on word select and outputs left/right sample pairs
module i2s_rx #(
  parameter int DATA_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  input  logic                 sclk,
  input  logic                 lr_clk,
  input  logic                 sdat,
  output logic [DATA_BITS-1:0] left_out,
  output logic [DATA_BITS-1:0] right_out,
  output logic                 out_tick,
  output logic                 slot_err,
  output logic                 locked
);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_BITS);
  localparam logic [DATA_BITS-1:0] MSB = {1'b1, {(DATA_BITS-1){1'b0}}};
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  logic [1:0]           sclk_s_q, lr_s_q, sd_s_q;
  logic                 sclk_dly_q, rise_q, ws_q, bit_q;
  logic                 prev_ws_q, prev_ws_d, prev_vld_q, prev_vld_d;
  state_t               st_q, st_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, stage_q, stage_d, left_q, left_d, right_q, right_d, word;
  logic                 lvld_q, lvld_d, tick_q, tick_d, err_q, err_d, lock_q, lock_d, chg, short_slot;
  // Two-flop synchronizers, then a registered sclk rising-edge strobe with data and word select captured alongside
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      sclk_s_q   <= '0;
      lr_s_q     <= '0;
      sd_s_q     <= '0;
      sclk_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      ws_q       <= 1'b0;
      bit_q      <= 1'b0;
    end else begin
      sclk_s_q   <= {sclk_s_q[0], sclk};
      lr_s_q     <= {lr_s_q[0], lr_clk};
      sd_s_q     <= {sd_s_q[0], sdat};
      sclk_dly_q <= sclk_s_q[1];
      rise_q     <= sclk_s_q[1] & ~sclk_dly_q;
      ws_q       <= lr_s_q[1];
      bit_q      <= sd_s_q[1];
    end
  end
  // Slot state, shift register and output registers
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      prev_ws_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      st_q       <= SYNC;
      cnt_q      <= '0;
      sh_q       <= '0;
      stage_q    <= '0;
      lvld_q     <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      prev_ws_q  <= prev_ws_d;
      prev_vld_q <= prev_vld_d;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      stage_q    <= stage_d;
      lvld_q     <= lvld_d;
      left_q     <= left_d;
      right_q    <= right_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
    end
  end
  // Bits land left-justified so a short slot is zero-filled; the word-select change bit closes the old slot
  always_comb begin
    prev_ws_d  = prev_ws_q;
    prev_vld_d = prev_vld_q;
    st_d       = st_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    stage_d    = stage_q;
    lvld_d     = lvld_q;
    left_d     = left_q;
    right_d    = right_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;
    lock_d     = lock_q;
    word       = (bit_q && cnt_q < FULL) ? (sh_q | (MSB >> cnt_q)) : sh_q;
    short_slot = cnt_q < FULL - 1'b1;
    chg        = rise_q && prev_vld_q && (ws_q != prev_ws_q);
    if (rise_q) begin
      prev_ws_d  = ws_q;
      prev_vld_d = 1'b1;
      if (chg) begin
        cnt_d = '0;
        sh_d  = '0;
        if (st_q == SYNC) begin
          st_d   = ws_q ? RIGHT : LEFT;
          lock_d = 1'b1;
        end else if (st_q == LEFT) begin
          err_d   = short_slot;
          stage_d = word;
          lvld_d  = 1'b1;
          st_d    = RIGHT;
        end else begin
          err_d   = short_slot;
          st_d    = LEFT;
          left_d  = lvld_q ? stage_q : left_q;
          right_d = lvld_q ? word : right_q;
          tick_d  = lvld_q;
        end
      end else if (st_q != SYNC && cnt_q < FULL) begin
        sh_d  = word;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  assign left_out  = left_q;
  assign right_out = right_q;
  assign out_tick  = tick_q;
  assign slot_err  = err_q;
  assign locked    = lock_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed self-checking bench for i2s_rx with sclk = CLK/8
module tb_i2s_rx;
  logic        CLK = 1'b0;
  logic        RSTb, sclk, lr_clk, sdat;
  logic [15:0] left_out, right_out;
  logic        out_tick, slot_err, locked;
  int          checks = 0, failures = 0, ticks = 0, errs = 0, t0, e0;
  logic [15:0] exp_l, exp_r;
  logic        spc;
  time         last_t;

  i2s_rx #(.DATA_BITS(16)) dut (
    .CLK(CLK), .RSTb(RSTb), .sclk(sclk), .lr_clk(lr_clk), .sdat(sdat),
    .left_out(left_out), .right_out(right_out), .out_tick(out_tick),
    .slot_err(slot_err), .locked(locked)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (out_tick === 1'b1) ticks++;
    if (slot_err === 1'b1) errs++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One sclk period: lr/sdat change with the falling edge; optionally check the pair 4 CLK edges after the rising edge
  task automatic send_bit(input logic l, input logic b, input logic c);
    sclk = 1'b0; lr_clk = l; sdat = b;
    #40 sclk = 1'b1;
    if (c) begin
      #30 chk("tick_early", 32'(out_tick), 0);
      #6 chk("tick", 32'(out_tick), 1);
      chk("left", 32'(left_out), 32'(exp_l));
      chk("right", 32'(right_out), 32'(exp_r));
      if (spc) chk("spacing", 32'($time - last_t), 2560);
      last_t = $time;
      #4;
    end else #40;
  endtask

  // The LSB of a slot goes out with the next slot's word select
  task automatic send_slot(input logic ws, input logic [31:0] v, input int n, input logic c);
    for (int i = n - 1; i >= 0; i--) send_bit(i == 0 ? ~ws : ws, v[i], c && ws && i == 0);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                            input logic [15:0] el, input logic [15:0] er);
    exp_l = el; exp_r = er;
    send_slot(1'b0, l, n, 1'b0);
    send_slot(1'b1, r, n, 1'b1);
  endtask

  initial begin
    RSTb = 1'b1; sclk = 1'b0; lr_clk = 1'b0; sdat = 1'b0;
    spc = 1'b0; last_t = 0; exp_l = '0; exp_r = '0;
    #1 RSTb = 1'b0;
    #21;
    chk("rst_left", 32'(left_out), 0);
    chk("rst_right", 32'(right_out), 0);
    chk("rst_tick", 32'(out_tick), 0);
    chk("rst_err", 32'(slot_err), 0);
    chk("rst_locked", 32'(locked), 0);
    RSTb = 1'b1;
    repeat (4) send_bit(1'b1, 1'b1, 1'b0);
    chk("locked_pre", 32'(locked), 0);
    send_bit(1'b0, 1'b1, 1'b0);
    chk("locked", 32'(locked), 1);
    exp_l = 16'h1234; exp_r = 16'hABCD;
    send_slot(1'b0, 32'h1234, 16, 1'b0);
    chk("left_staged_only", 32'(left_out), 0);
    chk("no_tick_after_left", 32'(ticks), 0);
    send_slot(1'b1, 32'hABCD, 16, 1'b1);
    chk("ticks_16", 32'(ticks), 1);
    chk("errs_16", 32'(errs), 0);
    send_slot(1'b0, 32'h8001_5555, 32, 1'b0);
    chk("left_hold", 32'(left_out), 32'h1234);
    chk("right_hold", 32'(right_out), 32'hABCD);
    exp_l = 16'h8001; exp_r = 16'h7FFE;
    send_slot(1'b1, 32'h7FFE_AAAA, 32, 1'b1);
    chk("ticks_32", 32'(ticks), 2);
    chk("errs_32", 32'(errs), 0);
    send_frame(32'hABC, 32'h123, 12, 16'hABC0, 16'h1230);
    chk("ticks_12", 32'(ticks), 3);
    chk("errs_12", 32'(errs), 2);
    send_frame(32'h5A5A, 32'h0F0F, 16, 16'h5A5A, 16'h0F0F);
    chk("ticks_back16", 32'(ticks), 4);
    chk("errs_back16", 32'(errs), 2);
    repeat (8) send_bit(1'b0, 1'b1, 1'b0);
    RSTb = 1'b0;
    #1;
    chk("arst_left", 32'(left_out), 0);
    chk("arst_right", 32'(right_out), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_tick", 32'(out_tick), 0);
    #39 RSTb = 1'b1;
    repeat (3) send_bit(1'b0, 1'b0, 1'b0);
    chk("relock_pre", 32'(locked), 0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("relock", 32'(locked), 1);
    t0 = ticks; e0 = errs;
    send_slot(1'b1, 32'h9999, 16, 1'b0);
    chk("no_tick_right_only", 32'(ticks - t0), 0);
    chk("right_only_out", 32'(right_out), 0);
    send_frame(32'h1357, 32'h2468, 16, 16'h1357, 16'h2468);
    chk("ticks_relock", 32'(ticks - t0), 1);
    chk("errs_relock", 32'(errs - e0), 0);
    t0 = ticks; e0 = errs;
    for (int k = 0; k < 10; k++) begin
      spc = (k > 0);
      send_frame(32'h1000 + 32'(k), 32'h2000 + 32'(k), 16, 16'h1000 + 16'(k), 16'h2000 + 16'(k));
    end
    spc = 1'b0;
    #200;
    chk("ticks_ten", 32'(ticks - t0), 10);
    chk("errs_ten", 32'(errs - e0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
